// File: rtl/weight_pkg.sv
// Shared definitions for the weight fetch path.
// Contents:
//   state_t     - loader FSM states (IDLE, FETCH, FLUSH, DONE)
//   SKID_DEPTH  - number of row slots in the output skid buffer
//   row_width() - bits in one packed weight row
package weight_pkg;

   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One row holds array_size signed weights of data_width bits each.
   function automatic int row_width(input int array_size, input int data_width);
      return array_size * data_width;
   endfunction

endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry register FIFO that sits between the SRAM return path and the
// weight FIFO. Slot 0 is always the head, so the head data and valid come
// straight out of flops and never depend on pop in the same cycle.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   push        - write push_data at the tail this cycle
//   push_data   - row plus its last flag (MSB)
//   pop         - consume the head this cycle (ignored when empty)
//   head_data   - current head entry
//   head_valid  - buffer holds at least one entry
//   count       - number of occupied slots (0..2)
module weight_skid_buf
   import weight_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [1:0]       count
);

   localparam logic [1:0] FULL = 2'(SKID_DEPTH);

   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic             pop_ok;

   assign pop_ok     = pop && (count != 2'd0);
   assign head_data  = slot0;
   assign head_valid = (count != 2'd0);

   // Occupancy update. When both slots are full and a push and pop coincide,
   // the second slot shifts forward and the new row lands behind it, so the
   // occupancy stays at two and ordering is preserved.
   always_ff @(posedge clk) begin
      if (!reset) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  slot0 <= push_data;
                  count <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop_ok) begin
                  slot0 <= push_data;
               end else if (push) begin
                  slot1 <= push_data;
                  count <= 2'd2;
               end else if (pop_ok) begin
                  count <= 2'd0;
               end
            end
            default: begin
               if (push && pop_ok) begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end else if (pop_ok) begin
                  slot0 <= slot1;
                  count <= 2'd1;
               end
            end
         endcase
      end
   end

   // The loader only issues a read when a slot is guaranteed to be free on
   // return, so a push into a full buffer without a pop means that credit
   // accounting upstream is broken.
   no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && !pop_ok && (count == FULL)));

endmodule

// File: rtl/weight_fifo_loader.sv
// Fetch stage feeding the weight FIFO. On start it reads num_rows
// consecutive rows from the weight SRAM beginning at base_addr and pushes
// them downstream over valid/ready, absorbing the 1-cycle SRAM latency and
// downstream stalls in a 2-entry skid buffer.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   start                 - job command strobe, only honoured in IDLE
//   base_addr, num_rows   - job parameters, captured with start
//   busy, done            - job status; done pulses once at job end
//   mem_rd_en, mem_addr   - SRAM read request
//   mem_rd_data           - SRAM data, valid the cycle after mem_rd_en
//   out_valid, out_ready  - handshake towards the weight FIFO
//   out_data, out_last    - row payload and final-row marker
module weight_fifo_loader
   import weight_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_SIZE = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic [CNT_WIDTH-1:0]             num_rows,
   output logic                             busy,
   output logic                             done,
   output logic                             mem_rd_en,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_rd_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
   output logic                             out_last
);

   localparam int ROW_WIDTH = row_width(ARRAY_SIZE, DATA_WIDTH);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [CNT_WIDTH-1:0]    num_q;
   logic [CNT_WIDTH-1:0]    issue_cnt;
   logic [CNT_WIDTH-1:0]    ret_cnt;
   logic [CNT_WIDTH-1:0]    last_idx;
   logic                    rd_pending;
   logic                    handshake;
   logic                    push_last;
   logic [1:0]              buf_count;
   logic [1:0]              credit;
   logic                    head_valid;
   logic [ROW_WIDTH:0]      head_data;

   // Credit counts rows already buffered plus the one read that may be in
   // flight. A read may go out while credit is below two, or at two when a
   // row leaves this very cycle, which keeps one row per cycle flowing with
   // out_ready held high.
   assign handshake = head_valid && out_ready;
   assign credit    = buf_count + {1'b0, rd_pending};
   assign mem_rd_en = (state == FETCH) &&
                      ((credit < 2'd2) || ((credit == 2'd2) && handshake));
   assign mem_addr  = (state == FETCH) ? (base_q + ADDR_WIDTH'(issue_cnt)) : '0;

   // The emit index travels with each row as it enters the buffer, so the
   // last flag is decided on the way in and simply rides along to the head.
   assign last_idx  = num_q - CNT_WIDTH'(1);
   assign push_last = (ret_cnt == last_idx);

   assign out_valid = head_valid;
   assign out_data  = head_data[ROW_WIDTH-1:0];
   assign out_last  = head_valid && head_data[ROW_WIDTH];

   // Return data is written unconditionally the cycle after a read; clearing
   // rd_pending on reset drops whatever the SRAM returns afterwards.
   weight_skid_buf #(
      .WIDTH(ROW_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_pending),
      .push_data ({push_last, mem_rd_data}),
      .pop       (handshake),
      .head_data (head_data),
      .head_valid(head_valid),
      .count     (buf_count)
   );

   // Job sequencing. FETCH issues reads until the last address has gone out,
   // FLUSH then waits for the final row to leave the buffer, and DONE holds
   // the done pulse for a single cycle. FLUSH looks ahead at the pop in the
   // current cycle so done lands in the cycle right after the last handshake.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         base_q     <= '0;
         num_q      <= '0;
         issue_cnt  <= '0;
         ret_cnt    <= '0;
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= mem_rd_en;
         done       <= 1'b0;
         if (rd_pending) begin
            ret_cnt <= ret_cnt + CNT_WIDTH'(1);
         end
         case (state)
            IDLE: begin
               if (start) begin
                  base_q    <= base_addr;
                  num_q     <= num_rows;
                  issue_cnt <= '0;
                  ret_cnt   <= '0;
                  busy      <= 1'b1;
                  if (num_rows == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (mem_rd_en) begin
                  issue_cnt <= issue_cnt + CNT_WIDTH'(1);
                  if (issue_cnt == last_idx) begin
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (!rd_pending &&
                   ((buf_count == 2'd0) || ((buf_count == 2'd1) && handshake))) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Directed bench for weight_fifo_loader. A small SRAM model returns each
// address replicated into every weight lane; each job is recorded cycle by
// cycle (cycle 0 is the start cycle) and then checked against expected
// addresses, row data, last flags, done timing and stall behaviour.
module tb_weight_fifo_loader;

   localparam int DW   = 8;
   localparam int AS   = 4;
   localparam int AW   = 10;
   localparam int CW   = 10;
   localparam int RW   = DW * AS;
   localparam int MAXC = 48;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] num_rows = '0;
   logic          busy;
   logic          done;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [RW-1:0] mem_rd_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [RW-1:0] out_data;
   logic          out_last;

   int checks = 0;
   int failures = 0;

   logic          recEn[MAXC];
   logic [AW-1:0] recAddr[MAXC];
   logic          recValid[MAXC];
   logic          recReady[MAXC];
   logic [RW-1:0] recData[MAXC];
   logic          recLast[MAXC];
   logic          recDone[MAXC];
   logic          recBusy[MAXC];
   int            recLen = 0;

   weight_fifo_loader #(
      .DATA_WIDTH(DW),
      .ARRAY_SIZE(AS),
      .ADDR_WIDTH(AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .num_rows   (num_rows),
      .busy       (busy),
      .done       (done),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] wordFor(input logic [AW-1:0] a);
      return {AS{a[7:0]}};
   endfunction

   // SRAM model: data is only meaningful the cycle after a read, junk otherwise.
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? wordFor(mem_addr) : 32'hDEADBEEF;
   end

   // Global time limit so the bench cannot hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic recordCycle(input int k);
      recEn[k]    = mem_rd_en;
      recAddr[k]  = mem_addr;
      recValid[k] = out_valid;
      recReady[k] = out_ready;
      recData[k]  = out_data;
      recLast[k]  = out_last;
      recDone[k]  = done;
      recBusy[k]  = busy;
      recLen      = k + 1;
   endtask

   // Runs one job: start in cycle 0, out_ready low for stallLen cycles from
   // stallFrom, and a bogus start with other parameters in cycle ignCycle.
   task automatic applyStimulus(input logic [AW-1:0] base, input logic [CW-1:0] n,
                                input int stallFrom, input int stallLen, input int ignCycle);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = base;
      num_rows  = n;
      out_ready = 1'b1;
      @(negedge clk);
      recordCycle(0);
      for (int k = 1; k < MAXC; k++) begin
         @(posedge clk); #1;
         start     = (k == ignCycle);
         base_addr = (k == ignCycle) ? 10'h155 : base;
         num_rows  = (k == ignCycle) ? 10'd9 : n;
         out_ready = !((k >= stallFrom) && (k < stallFrom + stallLen));
         @(negedge clk);
         recordCycle(k);
         if (done) break;
      end
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   // Walks the recorded job and checks addresses, rows, last flags,
   // outstanding reads, stall stability, busy and done.
   task automatic checkJob(input string tag, input logic [AW-1:0] base, input int n);
      int hs = 0;
      int issued = 0;
      int doneCnt = 0;
      int doneAt = -1;
      int lastHs = -1;
      int maxOut = 0;
      int unstable = 0;
      int busyBad = 0;
      logic [AW-1:0] a;
      for (int k = 0; k < recLen; k++) begin
         if (recEn[k]) begin
            a = base + AW'(issued);
            checkOutput($sformatf("%s addr%0d", tag, issued), 64'(recAddr[k]), 64'(a));
            issued++;
         end
         if (recValid[k] && recReady[k]) begin
            a = base + AW'(hs);
            checkOutput($sformatf("%s row%0d data", tag, hs), 64'(recData[k]), 64'(wordFor(a)));
            checkOutput($sformatf("%s row%0d last", tag, hs), 64'(recLast[k]), 64'(hs == n - 1));
            lastHs = k;
            hs++;
         end
         if (issued - hs > maxOut) maxOut = issued - hs;
         if (recValid[k] && !recReady[k] && (k + 1 < recLen)) begin
            if (!recValid[k + 1] || (recData[k + 1] !== recData[k])) unstable++;
         end
         if (recDone[k]) begin
            doneCnt++;
            doneAt = k;
         end
         if ((k == 0) == recBusy[k]) busyBad++;
      end
      checkOutput({tag, " rowCount"}, 64'(hs), 64'(n));
      checkOutput({tag, " readCount"}, 64'(issued), 64'(n));
      checkOutput({tag, " outstandingOver2"}, 64'(maxOut > 2), 64'd0);
      checkOutput({tag, " unstableStalls"}, 64'(unstable), 64'd0);
      checkOutput({tag, " donePulses"}, 64'(doneCnt), 64'd1);
      checkOutput({tag, " doneCycle"}, 64'(doneAt), 64'((n == 0) ? 1 : lastHs + 1));
      checkOutput({tag, " busyWindow"}, 64'(busyBad), 64'd0);
   endtask

   initial begin
      int firstEn;
      int firstValid;
      int stalls;
      int cnt;
      logic [AW-1:0] wrapExp[4];
      wrapExp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

      $display("[TB] weight_fifo_loader bench starting");

      // Reset state.
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset rdEn", 64'(mem_rd_en), 64'd0);
      checkOutput("reset outValid", 64'(out_valid), 64'd0);
      checkOutput("reset outData", 64'(out_data), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Basic job with exact cycle placement.
      applyStimulus(10'h010, 10'd4, 0, 0, -1);
      checkJob("basic", 10'h010, 4);
      firstEn = -1;
      firstValid = -1;
      for (int k = 0; k < recLen; k++) begin
         if (recEn[k] && firstEn < 0) firstEn = k;
         if (recValid[k] && firstValid < 0) firstValid = k;
      end
      checkOutput("basic firstRead", 64'(firstEn), 64'd1);
      checkOutput("basic firstValid", 64'(firstValid), 64'd3);
      checkOutput("basic addrCycle4", 64'(recAddr[4]), 64'h013);
      checkOutput("basic validCycle6", 64'(recValid[6]), 64'd1);
      checkOutput("basic lastCycle6", 64'(recLast[6]), 64'd1);
      checkOutput("basic doneCycle7", 64'(recDone[7]), 64'd1);

      // Backpressure: five stalled cycles right after the first row.
      applyStimulus(10'h080, 10'd6, 4, 5, -1);
      checkJob("backpressure", 10'h080, 6);
      stalls = 0;
      for (int k = 0; k < recLen; k++) begin
         if (recValid[k] && !recReady[k]) stalls++;
      end
      checkOutput("backpressure stalledCycles", 64'(stalls), 64'd5);
      checkOutput("backpressure rdEnDuringStall", 64'(recEn[7]), 64'd0);

      // Address wrap at the top of the SRAM.
      applyStimulus(10'h3FE, 10'd4, 0, 0, -1);
      checkJob("wrap", 10'h3FE, 4);
      cnt = 0;
      for (int k = 0; k < recLen; k++) begin
         if (recEn[k] && cnt < 4) begin
            checkOutput($sformatf("wrap seq%0d", cnt), 64'(recAddr[k]), 64'(wrapExp[cnt]));
            cnt++;
         end
      end

      // Zero-length job.
      applyStimulus(10'h100, 10'd0, 0, 0, -1);
      checkJob("zero", 10'h100, 0);
      cnt = 0;
      for (int k = 0; k < recLen; k++) begin
         if (recEn[k] || recValid[k]) cnt++;
      end
      checkOutput("zero activity", 64'(cnt), 64'd0);

      // Ignored start while busy.
      applyStimulus(10'h040, 10'd3, 0, 0, 2);
      checkJob("ignored", 10'h040, 3);
      @(negedge clk);
      checkOutput("ignored idleBusy", 64'(busy), 64'd0);
      checkOutput("ignored idleRdEn", 64'(mem_rd_en), 64'd0);

      // Reset mid-job: fill the buffer, then reset while a read is issued.
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = 10'h020;
      num_rows  = 10'd6;
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      @(negedge clk);
      checkOutput("midreset fullValid", 64'(out_valid), 64'd1);
      checkOutput("midreset fullRdEn", 64'(mem_rd_en), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      reset     = 1'b0;
      @(negedge clk);
      checkOutput("midreset inflightRdEn", 64'(mem_rd_en), 64'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset busy", 64'(busy), 64'd0);
      checkOutput("midreset done", 64'(done), 64'd0);
      checkOutput("midreset rdEn", 64'(mem_rd_en), 64'd0);
      checkOutput("midreset addr", 64'(mem_addr), 64'd0);
      checkOutput("midreset outValid", 64'(out_valid), 64'd0);
      checkOutput("midreset outData", 64'(out_data), 64'd0);
      checkOutput("midreset outLast", 64'(out_last), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("midreset discarded", 64'(out_valid), 64'd0);
      applyStimulus(10'h030, 10'd2, 0, 0, -1);
      checkJob("afterReset", 10'h030, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
